// File: rtl/pma_rule_table_if.sv
// ---------------------------------------------------------------------------
// pma_rule_table_if
// Purpose : bundles the configuration port and the per-port lookup/response
//           channels of pma_rule_table.
// Signals : cfg_req_i/cfg_we_i/cfg_idx_i/cfg_field_i/cfg_wdata_i  config request
//           cfg_rvalid_o/cfg_rdata_o/cfg_err_o                  config response
//           lookup_valid_i/lookup_ready_o/lookup_addr_i          lookup request
//           rsp_valid_o/rsp_ready_i/rsp_hit_o/rsp_nonidem_o/
//           rsp_exec_o/rsp_cache_o                               lookup result
// Modports: master = requester (drives the *_i signals)
//           slave  = the rule table (drives the *_o signals)
// ---------------------------------------------------------------------------
interface pma_rule_table_if #(
    parameter int NrRules   = 16,
    parameter int NrPorts   = 2,
    parameter int AddrWidth = 64
);
    localparam int IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1;

    logic                                cfg_req_i;
    logic                                cfg_we_i;
    logic [IdxWidth-1:0]                 cfg_idx_i;
    logic [1:0]                          cfg_field_i;
    logic [AddrWidth-1:0]                cfg_wdata_i;
    logic                                cfg_rvalid_o;
    logic [AddrWidth-1:0]                cfg_rdata_o;
    logic                                cfg_err_o;

    logic [NrPorts-1:0]                  lookup_valid_i;
    logic [NrPorts-1:0]                  lookup_ready_o;
    logic [NrPorts-1:0][AddrWidth-1:0]   lookup_addr_i;
    logic [NrPorts-1:0]                  rsp_valid_o;
    logic [NrPorts-1:0]                  rsp_ready_i;
    logic [NrPorts-1:0]                  rsp_hit_o;
    logic [NrPorts-1:0]                  rsp_nonidem_o;
    logic [NrPorts-1:0]                  rsp_exec_o;
    logic [NrPorts-1:0]                  rsp_cache_o;

    modport master (
        output cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
        input  cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
        output lookup_valid_i, lookup_addr_i, rsp_ready_i,
        input  lookup_ready_o, rsp_valid_o, rsp_hit_o, rsp_nonidem_o,
               rsp_exec_o, rsp_cache_o
    );

    modport slave (
        input  cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
        output cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
        input  lookup_valid_i, lookup_addr_i, rsp_ready_i,
        output lookup_ready_o, rsp_valid_o, rsp_hit_o, rsp_nonidem_o,
               rsp_exec_o, rsp_cache_o
    );
endinterface

// File: rtl/pma_rule_table.sv
// ---------------------------------------------------------------------------
// pma_rule_table
// Purpose : runtime-programmable physical-memory-attribute checker. Holds
//           NrRules {base, len, attr} entries written through a config port
//           and answers NrPorts independent address lookups, each through a
//           single backpressured output register (latency 1).
// Ports   : clk_i  clock
//           rst_i  asynchronous active-high reset
//           bus    pma_rule_table_if.slave (config + lookup channels)
// Attr    : {lock, valid, cache, exec, nonidem} = bits [4:0]
// ---------------------------------------------------------------------------
module pma_rule_table #(
    parameter int                           NrRules   = 16,
    parameter int                           NrPorts   = 2,
    parameter int                           AddrWidth = 64,
    parameter logic [NrRules*AddrWidth-1:0] RstBase   = '0,
    parameter logic [NrRules*AddrWidth-1:0] RstLen    = '0,
    parameter logic [NrRules*5-1:0]         RstAttr   = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pma_rule_table_if.slave    bus
);
    localparam int IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1;

    localparam int AttrLock    = 4;
    localparam int AttrValid   = 3;
    localparam int AttrCache   = 2;
    localparam int AttrExec    = 1;
    localparam int AttrNonidem = 0;

    logic [AddrWidth-1:0] w_base [NrRules];
    logic [AddrWidth-1:0] w_len  [NrRules];
    logic [4:0]           w_attr [NrRules];
    // One extra bit so base+len never wraps past the top of the address space.
    logic [AddrWidth:0]   w_end  [NrRules];

    logic                 w_idx_ok;
    logic [IdxWidth-1:0]  w_idx;
    logic                 w_err;
    logic [AddrWidth-1:0] w_rd_field;

    // ---------------- config decode ----------------
    always_comb begin
        w_idx_ok   = (32'(bus.cfg_idx_i) < 32'(NrRules));
        // Clamp so the read mux never indexes past the table.
        w_idx      = w_idx_ok ? bus.cfg_idx_i : '0;
        // Lock only blocks writes; locked rules remain readable.
        w_err      = !w_idx_ok || (bus.cfg_field_i == 2'd3) ||
                     (bus.cfg_we_i && w_attr[w_idx][AttrLock]);
        w_rd_field = '0;
        case (bus.cfg_field_i)
            2'd0:    w_rd_field = w_base[w_idx];
            2'd1:    w_rd_field = w_len[w_idx];
            2'd2:    w_rd_field = AddrWidth'(w_attr[w_idx]);
            default: w_rd_field = '0;
        endcase
    end

    // ---------------- rule storage ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NrRules; gi++) begin : g_rule
            logic [AddrWidth-1:0] r_base;
            logic [AddrWidth-1:0] r_len;
            logic [4:0]           r_attr;
            logic                 w_wr;

            assign w_wr = bus.cfg_req_i && bus.cfg_we_i && !w_err &&
                          (32'(bus.cfg_idx_i) == 32'(gi));

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_base <= RstBase[gi*AddrWidth +: AddrWidth];
                    r_len  <= RstLen[gi*AddrWidth +: AddrWidth];
                    r_attr <= RstAttr[gi*5 +: 5];
                end else if (w_wr) begin
                    case (bus.cfg_field_i)
                        2'd0:    r_base <= bus.cfg_wdata_i;
                        2'd1:    r_len  <= bus.cfg_wdata_i;
                        2'd2:    r_attr <= bus.cfg_wdata_i[4:0];
                        default: ;
                    endcase
                end
            end

            assign w_base[gi] = r_base;
            assign w_len[gi]  = r_len;
            assign w_attr[gi] = r_attr;
            assign w_end[gi]  = {1'b0, r_base} + {1'b0, r_len};
        end
    endgenerate

    // ---------------- config response ----------------
    logic                 r_cfg_rvalid;
    logic                 r_cfg_err;
    logic [AddrWidth-1:0] r_cfg_rdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cfg_rvalid <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_cfg_rdata  <= '0;
        end else begin
            r_cfg_rvalid <= bus.cfg_req_i;
            r_cfg_err    <= bus.cfg_req_i && w_err;
            r_cfg_rdata  <= (bus.cfg_req_i && !bus.cfg_we_i && !w_err) ? w_rd_field : '0;
        end
    end

    assign bus.cfg_rvalid_o = r_cfg_rvalid;
    assign bus.cfg_err_o    = r_cfg_err;
    assign bus.cfg_rdata_o  = r_cfg_rdata;

    // ---------------- lookup match ----------------
    logic [NrPorts-1:0] w_hit, w_nonidem, w_exec, w_cache;
    logic [NrPorts-1:0] w_ready, w_accept;

    // Matching uses the registered table, so a same-cycle config write is
    // only visible to lookups accepted on later cycles.
    always_comb begin
        w_hit     = '0;
        w_nonidem = '0;
        w_exec    = '0;
        w_cache   = '0;
        for (int p = 0; p < NrPorts; p++) begin
            for (int k = 0; k < NrRules; k++) begin
                if (w_attr[k][AttrValid] &&
                    (bus.lookup_addr_i[p] >= w_base[k]) &&
                    ({1'b0, bus.lookup_addr_i[p]} < w_end[k])) begin
                    w_hit[p]     = 1'b1;
                    w_nonidem[p] = w_nonidem[p] | w_attr[k][AttrNonidem];
                    w_exec[p]    = w_exec[p]    | w_attr[k][AttrExec];
                    w_cache[p]   = w_cache[p]   | w_attr[k][AttrCache];
                end
            end
        end
    end

    // ---------------- per-port output registers ----------------
    logic [NrPorts-1:0] r_rsp_valid, r_rsp_hit, r_rsp_nonidem, r_rsp_exec, r_rsp_cache;

    assign w_ready  = ~r_rsp_valid | bus.rsp_ready_i;
    assign w_accept = bus.lookup_valid_i & w_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_valid   <= '0;
            r_rsp_hit     <= '0;
            r_rsp_nonidem <= '0;
            r_rsp_exec    <= '0;
            r_rsp_cache   <= '0;
        end else begin
            for (int p = 0; p < NrPorts; p++) begin
                // An accept in the pop cycle overwrites the slot: full throughput.
                if (w_accept[p]) begin
                    r_rsp_valid[p]   <= 1'b1;
                    r_rsp_hit[p]     <= w_hit[p];
                    r_rsp_nonidem[p] <= w_nonidem[p];
                    r_rsp_exec[p]    <= w_exec[p];
                    r_rsp_cache[p]   <= w_cache[p];
                end else if (bus.rsp_ready_i[p]) begin
                    r_rsp_valid[p]   <= 1'b0;
                end
            end
        end
    end

    assign bus.lookup_ready_o = w_ready;
    assign bus.rsp_valid_o    = r_rsp_valid;
    assign bus.rsp_hit_o      = r_rsp_hit;
    assign bus.rsp_nonidem_o  = r_rsp_nonidem;
    assign bus.rsp_exec_o     = r_rsp_exec;
    assign bus.rsp_cache_o    = r_rsp_cache;
endmodule

// File: tb/tb_pma_rule_table.sv
// ---------------------------------------------------------------------------
// tb_pma_rule_table
// Purpose : directed testbench for pma_rule_table (12 rules, 2 ports, 64-bit).
//           Rule 0 resets to [0x8000_0000, 0xC000_0000) valid|cache|exec.
// ---------------------------------------------------------------------------
module tb_pma_rule_table;
    localparam int NR = 12;
    localparam int NP = 2;
    localparam int AW = 64;

    localparam logic [NR*AW-1:0] RST_BASE = (NR*AW)'(64'h8000_0000);
    localparam logic [NR*AW-1:0] RST_LEN  = (NR*AW)'(64'h4000_0000);
    localparam logic [NR*5-1:0]  RST_ATTR = (NR*5)'(5'b01110);

    logic clk;
    logic rst;

    pma_rule_table_if #(.NrRules(NR), .NrPorts(NP), .AddrWidth(AW)) bus ();

    pma_rule_table #(
        .NrRules  (NR),
        .NrPorts  (NP),
        .AddrWidth(AW),
        .RstBase  (RST_BASE),
        .RstLen   (RST_LEN),
        .RstAttr  (RST_ATTR)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One config transaction: request this cycle, check the response next cycle.
    task automatic cfg_op(input logic we, input logic [3:0] idx, input logic [1:0] field,
                          input logic [63:0] wdata, input logic exp_err,
                          input logic [63:0] exp_rdata, input string name);
        bus.cfg_req_i   = 1'b1;
        bus.cfg_we_i    = we;
        bus.cfg_idx_i   = idx;
        bus.cfg_field_i = field;
        bus.cfg_wdata_i = wdata;
        @(posedge clk); #1;
        bus.cfg_req_i   = 1'b0;
        $display("cfg %s we=%0d idx=%0d field=%0d wdata=0x%0h -> rvalid=%0d err=%0d rdata=0x%0h",
                 name, we, idx, field, wdata, bus.cfg_rvalid_o, bus.cfg_err_o, bus.cfg_rdata_o);
        chk({name, " rvalid"}, 64'(bus.cfg_rvalid_o), 64'd1);
        chk({name, " err"},    64'(bus.cfg_err_o),    64'(exp_err));
        chk({name, " rdata"},  bus.cfg_rdata_o,       exp_rdata);
    endtask

    // Single lookup on port 0; res = {hit, nonidem, exec, cache}.
    task automatic lookup0(input logic [63:0] addr, output logic valid, output logic [3:0] res);
        bus.lookup_valid_i[0] = 1'b1;
        bus.lookup_addr_i[0]  = addr;
        bus.rsp_ready_i[0]    = 1'b1;
        @(posedge clk); #1;
        bus.lookup_valid_i[0] = 1'b0;
        valid = bus.rsp_valid_o[0];
        res   = {bus.rsp_hit_o[0], bus.rsp_nonidem_o[0], bus.rsp_exec_o[0], bus.rsp_cache_o[0]};
        $display("lookup p0 addr=0x%0h -> valid=%0d {hit,nonidem,exec,cache}=%b", addr, valid, res);
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  exp;   // {hit, nonidem, exec, cache}
    } lk_vec_t;

    lk_vec_t vecs [12];

    initial begin
        logic       v;
        logic [3:0] r;

        vecs[0]  = '{64'h0000_0000_8000_1000, 4'b1011};
        vecs[1]  = '{64'h0000_0000_C000_0000, 4'b0000};
        vecs[2]  = '{64'h0000_0000_7FFF_FFFF, 4'b0000};
        vecs[3]  = '{64'h0000_0000_BFFF_FFFF, 4'b1011};
        vecs[4]  = '{64'hFFFF_FFFF_FFFF_FFFF, 4'b1100};
        vecs[5]  = '{64'hFFFF_FFFF_FFFF_EFFF, 4'b0000};
        vecs[6]  = '{64'hFFFF_FFFF_FFFF_F000, 4'b1100};
        vecs[7]  = '{64'h0000_0000_0000_1900, 4'b1011};
        vecs[8]  = '{64'h0000_0000_0000_2100, 4'b1001};
        vecs[9]  = '{64'h0000_0000_0000_0FFF, 4'b0000};
        vecs[10] = '{64'h0000_0000_0000_2800, 4'b0000};
        vecs[11] = '{64'h0000_0000_0000_2000, 4'b1001};

        rst                = 1'b1;
        bus.cfg_req_i      = 1'b0;
        bus.cfg_we_i       = 1'b0;
        bus.cfg_idx_i      = '0;
        bus.cfg_field_i    = '0;
        bus.cfg_wdata_i    = '0;
        bus.lookup_valid_i = '0;
        bus.lookup_addr_i  = '0;
        bus.rsp_ready_i    = '1;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        $display("reset: rvalid=%0d rsp_valid=%b ready=%b", bus.cfg_rvalid_o, bus.rsp_valid_o, bus.lookup_ready_o);
        chk("rst cfg_rvalid", 64'(bus.cfg_rvalid_o), 64'd0);
        chk("rst cfg_rdata",  bus.cfg_rdata_o,       64'd0);
        chk("rst rsp_valid",  64'(bus.rsp_valid_o),  64'd0);
        chk("rst lookup_rdy", 64'(bus.lookup_ready_o), 64'd3);
        rst = 1'b0;

        // ---- program rules 1..3 ----
        cfg_op(1'b1, 4'd1, 2'd0, 64'hFFFF_FFFF_FFFF_F000, 1'b0, 64'd0, "wr r1 base");
        cfg_op(1'b1, 4'd1, 2'd1, 64'h2000,                1'b0, 64'd0, "wr r1 len");
        cfg_op(1'b1, 4'd1, 2'd2, 64'h09,                  1'b0, 64'd0, "wr r1 attr");
        cfg_op(1'b1, 4'd2, 2'd0, 64'h1000,                1'b0, 64'd0, "wr r2 base");
        cfg_op(1'b1, 4'd2, 2'd1, 64'h1000,                1'b0, 64'd0, "wr r2 len");
        cfg_op(1'b1, 4'd2, 2'd2, 64'h0A,                  1'b0, 64'd0, "wr r2 attr");
        cfg_op(1'b1, 4'd3, 2'd0, 64'h1800,                1'b0, 64'd0, "wr r3 base");
        cfg_op(1'b1, 4'd3, 2'd1, 64'h1000,                1'b0, 64'd0, "wr r3 len");
        cfg_op(1'b1, 4'd3, 2'd2, 64'h0C,                  1'b0, 64'd0, "wr r3 attr");
        cfg_op(1'b0, 4'd1, 2'd0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_F000, "rd r1 base");
        cfg_op(1'b0, 4'd0, 2'd2, 64'd0, 1'b0, 64'h0E, "rd r0 attr");

        // ---- table-driven lookups ----
        for (int i = 0; i < 12; i++) begin
            lookup0(vecs[i].addr, v, r);
            chk($sformatf("vec%0d valid", i), 64'(v), 64'd1);
            chk($sformatf("vec%0d result", i), 64'(r), 64'(vecs[i].exp));
        end

        // ---- len=0 never matches ----
        cfg_op(1'b1, 4'd1, 2'd1, 64'd0, 1'b0, 64'd0, "wr r1 len0");
        lookup0(64'hFFFF_FFFF_FFFF_F000, v, r);
        chk("len0 result", 64'(r), 64'd0);

        // ---- lock ----
        cfg_op(1'b1, 4'd4, 2'd0, 64'h5000, 1'b0, 64'd0,     "wr r4 base");
        cfg_op(1'b1, 4'd4, 2'd2, 64'h19,   1'b0, 64'd0,     "wr r4 lock");
        cfg_op(1'b1, 4'd4, 2'd0, 64'h1234, 1'b1, 64'd0,     "wr locked base");
        cfg_op(1'b0, 4'd4, 2'd0, 64'd0,    1'b0, 64'h5000,  "rd locked base");
        cfg_op(1'b1, 4'd4, 2'd2, 64'd0,    1'b1, 64'd0,     "wr unlock attr");
        cfg_op(1'b0, 4'd4, 2'd2, 64'd0,    1'b0, 64'h19,    "rd lock attr");
        cfg_op(1'b0, 4'd2, 2'd3, 64'd0,    1'b1, 64'd0,     "rd reserved");
        cfg_op(1'b1, 4'd12, 2'd0, 64'h55,  1'b1, 64'd0,     "wr idx oob");
        cfg_op(1'b0, 4'd12, 2'd0, 64'd0,   1'b1, 64'd0,     "rd idx oob");

        // ---- backpressure on port 1, port 0 streams ----
        bus.rsp_ready_i       = 2'b01;
        bus.lookup_valid_i    = 2'b11;
        bus.lookup_addr_i[0]  = 64'h1900;
        bus.lookup_addr_i[1]  = 64'h1900;
        @(posedge clk); #1;
        $display("bp load: p1 valid=%0d exec=%0d", bus.rsp_valid_o[1], bus.rsp_exec_o[1]);
        chk("bp p1 first valid", 64'(bus.rsp_valid_o[1]), 64'd1);
        chk("bp p1 first exec",  64'(bus.rsp_exec_o[1]),  64'd1);
        bus.lookup_addr_i[1] = 64'h2100;
        for (int i = 0; i < 3; i++) begin
            bus.lookup_addr_i[0] = (i % 2 == 0) ? 64'h2100 : 64'h1900;
            @(posedge clk); #1;
            $display("bp hold %0d: p1 valid=%0d exec=%0d rdy=%0d p0 valid=%0d exec=%0d", i,
                     bus.rsp_valid_o[1], bus.rsp_exec_o[1], bus.lookup_ready_o[1],
                     bus.rsp_valid_o[0], bus.rsp_exec_o[0]);
            chk($sformatf("bp%0d p1 valid", i), 64'(bus.rsp_valid_o[1]),    64'd1);
            chk($sformatf("bp%0d p1 exec", i),  64'(bus.rsp_exec_o[1]),     64'd1);
            chk($sformatf("bp%0d p1 ready", i), 64'(bus.lookup_ready_o[1]), 64'd0);
            chk($sformatf("bp%0d p0 valid", i), 64'(bus.rsp_valid_o[0]),    64'd1);
            chk($sformatf("bp%0d p0 exec", i),  64'(bus.rsp_exec_o[0]),     64'(i % 2 != 0));
        end
        bus.rsp_ready_i = 2'b11;
        #1;
        chk("bp release ready", 64'(bus.lookup_ready_o[1]), 64'd1);
        @(posedge clk); #1;
        $display("bp release: p1 valid=%0d exec=%0d cache=%0d", bus.rsp_valid_o[1], bus.rsp_exec_o[1], bus.rsp_cache_o[1]);
        chk("bp b2b p1 valid", 64'(bus.rsp_valid_o[1]), 64'd1);
        chk("bp b2b p1 exec",  64'(bus.rsp_exec_o[1]),  64'd0);
        chk("bp b2b p1 cache", 64'(bus.rsp_cache_o[1]), 64'd1);
        bus.lookup_valid_i = 2'b00;
        @(posedge clk); #1;
        chk("bp drain valid", 64'(bus.rsp_valid_o), 64'd0);

        // ---- same-cycle write and lookup ----
        bus.cfg_req_i         = 1'b1;
        bus.cfg_we_i          = 1'b1;
        bus.cfg_idx_i         = 4'd0;
        bus.cfg_field_i       = 2'd1;
        bus.cfg_wdata_i       = 64'd0;
        bus.lookup_valid_i[0] = 1'b1;
        bus.lookup_addr_i[0]  = 64'h8000_0000;
        @(posedge clk); #1;
        bus.cfg_req_i         = 1'b0;
        bus.lookup_valid_i[0] = 1'b0;
        $display("race: cfg err=%0d p0 hit=%0d", bus.cfg_err_o, bus.rsp_hit_o[0]);
        chk("race cfg err", 64'(bus.cfg_err_o), 64'd0);
        chk("race old hit", 64'(bus.rsp_hit_o[0]), 64'd1);
        lookup0(64'h8000_0000, v, r);
        chk("race new hit", 64'(r[3]), 64'd0);

        // ---- reset mid-operation ----
        bus.rsp_ready_i       = 2'b00;
        bus.lookup_valid_i[1] = 1'b1;
        bus.lookup_addr_i[1]  = 64'h1900;
        @(posedge clk); #1;
        bus.lookup_valid_i[1] = 1'b0;
        chk("pre-rst p1 valid", 64'(bus.rsp_valid_o[1]), 64'd1);
        bus.cfg_req_i   = 1'b1;
        bus.cfg_we_i    = 1'b0;
        bus.cfg_idx_i   = 4'd4;
        bus.cfg_field_i = 2'd0;
        rst = 1'b1;
        @(posedge clk); #1;
        bus.cfg_req_i = 1'b0;
        $display("mid rst: rvalid=%0d rsp_valid=%b ready=%b", bus.cfg_rvalid_o, bus.rsp_valid_o, bus.lookup_ready_o);
        chk("mid rst cfg_rvalid", 64'(bus.cfg_rvalid_o), 64'd0);
        chk("mid rst rsp_valid",  64'(bus.rsp_valid_o),  64'd0);
        chk("mid rst ready",      64'(bus.lookup_ready_o), 64'd3);
        rst = 1'b0;
        bus.rsp_ready_i = 2'b11;
        cfg_op(1'b1, 4'd4, 2'd0, 64'h1234, 1'b0, 64'd0,          "wr r4 after rst");
        cfg_op(1'b0, 4'd0, 2'd1, 64'd0,    1'b0, 64'h4000_0000,  "rd r0 len after rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pma_rule_table.md
Name: pma_rule_table

Overview:
Runtime-programmable physical-memory-attribute checker. It replaces the fixed, elaboration-time non-idempotent, execute and cacheable region lists with a register-held rule table of NrRules entries, programmed through a config port. It serves NrPorts independent lookup channels, each with a registered, backpressured response. It sits beside the MMU/PMP, feeding the fetch and load/store paths.

Parameters:
NrRules, 16, number of rule entries (1..64)
NrPorts, 2, number of independent lookup channels (1..4)
AddrWidth, 64, address/base/length width
RstBase, '0, NrRules x AddrWidth reset base per rule
RstLen, '0, NrRules x AddrWidth reset length per rule
RstAttr, '0, NrRules x 5 reset attribute per rule {lock,valid,cache,exec,nonidem}

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
cfg_req_i  in  1  config access request, always accepted
cfg_we_i  in  1  1=write, 0=read
cfg_idx_i  in  $clog2(NrRules)  rule index
cfg_field_i  in  2  0=base, 1=len, 2=attr, 3=reserved
cfg_wdata_i  in  AddrWidth  write data (attr uses bits [4:0])
cfg_rvalid_o  out  1  response valid, one cycle after request
cfg_rdata_o  out  AddrWidth  read data (0 for writes and errors)
cfg_err_o  out  1  response error, qualified by cfg_rvalid_o
lookup_valid_i  in  NrPorts  lookup request per port
lookup_ready_o  out  NrPorts  port can accept a request
lookup_addr_i  in  NrPorts x AddrWidth  physical address
rsp_valid_o  out  NrPorts  result valid
rsp_ready_i  in  NrPorts  consumer accepts result
rsp_hit_o  out  NrPorts  at least one valid rule matched
rsp_nonidem_o  out  NrPorts  OR of nonidem over matching rules
rsp_exec_o  out  NrPorts  OR of exec over matching rules
rsp_cache_o  out  NrPorts  OR of cache over matching rules

Behaviour:
- Reset (async assert): rule regs <= RstBase/RstLen/RstAttr. cfg_rvalid_o, cfg_err_o, cfg_rdata_o = 0. All rsp_* = 0. lookup_ready_o = all ones.
- Match for rule k: valid_k && addr >= base_k && {1'b0,addr} < ({1'b0,base_k} + {1'b0,len_k}). The sum is (AddrWidth+1) bits, so there is no wrap. len=0 never matches. base+len above 2^AddrWidth matches up to the top address.
- Results: rsp_hit is the OR over matching rules; each attribute is the OR over matching rules. No hit gives all attributes 0 (idempotent, non-executable, non-cacheable).
- Lookup pipeline: one output register per port.
  - lookup_ready_o[p] = !rsp_valid_o[p] || rsp_ready_i[p].
  - On lookup_valid_i && lookup_ready_o, the result is computed from the table state at the start of that cycle and registered. rsp_valid_o is asserted next cycle; latency is 1.
  - rsp_valid_o stays high and rsp_* stay stable until rsp_ready_i.
  - A new accept in the same cycle as a pop replaces the register, giving full throughput.
  - Ports are fully independent; there is no arbitration.
- Config access:
  - Every cfg_req_i gets exactly one response the next cycle: cfg_rvalid_o=1 for 1 cycle.
  - Reads return the field. attr is zero-extended to AddrWidth. Reserved field reads 0 with err=1.
  - Writes update the field at the clock edge.
  - Error, with no state change, when: cfg_idx_i >= NrRules, field=3, or lock_k=1 for any field. This includes writes to attr, so lock can only be cleared by reset.
  - Writing attr with lock=1 sets lock in that same write.
- Simultaneous config write and lookup in one cycle: the lookup sees the pre-write table. A lookup accepted the following cycle sees the new value.
- A held (stalled) response is not recomputed when the table changes.
- Reset mid-operation: pending responses are dropped, and cfg_rvalid_o is not generated for a request in the reset cycle.

Test Plan:
- Reset defaults: RstBase[0]=0x8000_0000, RstLen[0]=0x4000_0000, RstAttr[0]=5'b01110. Lookup 0x8000_1000 on port 0 -> next cycle rsp_valid=1, hit=1, exec=1, cache=1, nonidem=0. Lookup 0xC000_0000 -> hit=0, all attributes 0.
- Boundary/overflow: program rule1 base=0xFFFF_FFFF_FFFF_F000, len=0x2000, attr=valid|nonidem. Addr 0xFFFF_FFFF_FFFF_FFFF -> hit=1, nonidem=1. Addr 0xFFFF_FFFF_FFFF_EFFF -> hit=0. len=0 -> no match at base.
- Overlap OR: rule2 [0x1000,0x2000) exec, rule3 [0x1800,0x2800) cache. Addr 0x1900 -> exec=1, cache=1. Addr 0x2100 -> exec=0, cache=1.
- Lock: write attr=5'b11001 to rule4, then base write -> cfg_err_o=1 and readback unchanged. Attr write clearing lock -> err=1 and lock stays set. After reset the rule is writable again.
- Backpressure: port1 rsp_ready_i=0 for 3 cycles -> lookup_ready_o[1]=0, response held stable. Port0 continues 1 result/cycle. Releasing ready with a same-cycle new request -> back-to-back valid.
- Write/lookup race: same-cycle write of rule0 len=0 and port0 lookup of 0x8000_0000 -> hit=1. Lookup the next cycle -> hit=0. idx=NrRules write -> err=1, rdata=0.
